io_ccff_loader: RTL and testbench
=================================

Name: io_ccff_loader

Overview:
- Sequences configuration of a chain of IO tiles. It holds the tiles isolated, serializes configuration words onto their ccff chain one bit per prog_clk, and releases isolation once the load completes.
- Sits between the SoC-side configuration port and the ccff_head / ccff_tail / isol_n pins of the IO tile chain; the chain sees this block as its only driver.

Parameters:
- CHAIN_LEN, 12, total ccff bits in the IO chain (>=1).
- WORD_W, 8, width of the configuration word input (>=1).
- ISO_CYCLES, 4, prog_clk cycles isol_n is held low before the first shift and after the last shift (>=1).

Ports:
- prog_clk  in  1  configuration clock; all state is on its rising edge.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a load sequence; ignored unless state is IDLE or ERR.
- cfg_valid  in  1  cfg_data/cfg_last valid.
- cfg_ready  out  1  word accepted on a cycle where cfg_valid && cfg_ready.
- cfg_data  in  WORD_W  configuration word, shifted LSB first.
- cfg_last  in  1  marks the final word of the load.
- ccff_head  out  1  serial bit into the IO chain.
- ccff_tail  in  1  serial bit out of the IO chain.
- ccff_shift_en  out  1  chain clock enable; the chain advances one bit on each prog_clk edge where it is 1.
- isol_n  out  1  active-low isolation to all IO tiles.
- busy  out  1  high in every state except IDLE and ERR.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values: cfg_ready=0, ccff_head=0, ccff_shift_en=0, isol_n=0, busy=0, done=0, err=0, state=IDLE.
  - isol_n stays 0 until the first successful load.
- All outputs are registered.
- IDLE:
  - start -> ISOLATE.
  - isol_n keeps its last value: 1 after a successful load, 0 after reset.
- ISOLATE:
  - isol_n=0; wait ISO_CYCLES cycles, then -> LOAD.
- LOAD:
  - Word register empty: cfg_ready=1.
  - On accept, the word is latched and cfg_ready=0.
  - On each following cycle, ccff_head = next bit (LSB first) with ccff_shift_en=1.
  - Bits per word: WORD_W, except the final word, which shifts only CHAIN_LEN - WORD_W*(NWORDS-1) bits, where NWORDS = ceil(CHAIN_LEN/WORD_W). Unused upper bits of the final word are discarded.
  - Empty cycles have ccff_shift_en=0 (one bubble cycle per word).
  - A global bit counter (width $clog2(CHAIN_LEN+1)) counts shifted bits.
- Word-count checks:
  - cfg_last on a word other than word NWORDS, or cfg_last=0 on word NWORDS: set err, ccff_shift_en=0, -> ERR. No bits of that word are shifted.
- LOAD exit:
  - When the counter reaches CHAIN_LEN -> VERIFY if CCFF_VERIFY_EN is defined, else -> RELEASE.
- RELEASE:
  - ccff_shift_en=0, isol_n=0 for ISO_CYCLES cycles.
  - Then isol_n=1, done=1 for one cycle, -> IDLE.
- ERR:
  - isol_n=0, cfg_ready=0, busy=0.
  - Leaves only on start (clears err, -> ISOLATE).
- Boundary rules:
  - start while busy is ignored.
  - cfg_valid outside LOAD is ignored; no accept occurs.
  - Asynchronous reset mid-sequence forces the reset values immediately. The chain contents are undefined afterwards and stay isolated.
  - CHAIN_LEN < WORD_W: NWORDS=1.
  - CHAIN_LEN an exact multiple of WORD_W: the final word shifts all WORD_W bits.

Optional Feature:
- CCFF_VERIFY_EN, defined:
  - LOAD keeps a running XOR parity of all shifted bits.
  - VERIFY runs CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation restores the chain contents), XOR-accumulating ccff_tail.
  - At the end, a parity mismatch sets err and -> ERR with isol_n=0; a match -> RELEASE.
- CCFF_VERIFY_EN, undefined:
  - No VERIFY state and no parity logic; ccff_tail is unused.

Test Plan:
- Defaults; start, then words 0xA5 (cfg_last=0) and 0x3C (cfg_last=1) -> ccff_head over the 12 shift-enabled cycles = 1,0,1,0,0,1,0,1,0,0,1,1.
  - isol_n=0 from the cycle after start until ISO_CYCLES after the last shift; then isol_n=1 and a single done pulse.
- cfg_last=1 on the first word (0xFF) -> err=1, no shift-enabled cycles, busy=0, isol_n=0, cfg_ready=0.
  - A following start clears err and the full two-word load succeeds.
- cfg_valid held low for 5 cycles mid-LOAD -> ccff_shift_en=0 on those cycles, bit counter frozen, final chain contents unchanged.
- prog_reset asserted after 6 bits shifted -> all outputs at reset values immediately, including isol_n=0.
  - After reset releases, the next start performs a full 12-bit load.
- CHAIN_LEN=16, WORD_W=8, words 0x01, 0x80 -> exactly 16 shift cycles, no discarded bits, done asserted once.
- CCFF_VERIFY_EN defined with a bench chain model: correct chain -> 12 recirculation cycles, chain contents restored, done.
  - Model with one bit inverted -> err=1, isol_n stays 0.

Source files
------------

// File: rtl/io_ccff_loader_if.sv
// Pin bundle of io_ccff_loader: SoC-side configuration port plus the IO-chain ccff/isolation pins.
// master = whoever drives the loader's inputs (SoC and chain tail), slave = the loader itself.
interface io_ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_last;
  logic              ccff_head;
  logic              ccff_tail;
  logic              ccff_shift_en;
  logic              isol_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, cfg_valid, cfg_data, cfg_last, ccff_tail,
    input  cfg_ready, ccff_head, ccff_shift_en, isol_n, busy, done, err
  );

  modport slave (
    input  start, cfg_valid, cfg_data, cfg_last, ccff_tail,
    output cfg_ready, ccff_head, ccff_shift_en, isol_n, busy, done, err
  );
endinterface

// File: rtl/io_ccff_loader.sv
// Isolates the IO tile chain, serializes configuration words LSB first onto ccff_head, then releases isolation.
// Define CCFF_VERIFY_EN to add a parity-checked recirculation pass (VERIFY) before release.
module io_ccff_loader #(
  parameter int CHAIN_LEN  = 12,
  parameter int WORD_W     = 8,
  parameter int ISO_CYCLES = 4
) (
  input  logic            prog_clk,
  input  logic            prog_reset,
  io_ccff_loader_if.slave bus
);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - WORD_W * (NWORDS - 1);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W     = $clog2(WORD_W + 1);
  localparam int IDX_W     = $clog2(NWORDS + 1);
  localparam int ISO_W     = $clog2(ISO_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [ISO_W-1:0] ISO_LAST  = ISO_W'(ISO_CYCLES - 1);
  localparam logic [BIT_W-1:0] FULL_LEFT = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] LAST_LEFT = BIT_W'(LAST_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISOLATE = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;
`ifdef CCFF_VERIFY_EN
  localparam logic [2:0] S_VERIFY  = 3'd3;
`endif

  logic [2:0]        state_q, state_d;
  logic [ISO_W-1:0]  iso_cnt_q, iso_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [BIT_W-1:0]  bits_left_q, bits_left_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              ccff_head_q, ccff_head_d;
  logic              shift_en_q, shift_en_d;
  logic              isol_n_q, isol_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef CCFF_VERIFY_EN
  logic              par_q, par_d;
  logic              tpar_q, tpar_d;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch of this block can infer a latch.
    state_d     = state_q;
    iso_cnt_d   = iso_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    bits_left_d = bits_left_q;
    word_d      = word_q;
    cfg_ready_d = cfg_ready_q;
    ccff_head_d = ccff_head_q;
    shift_en_d  = shift_en_q;
    isol_n_d    = isol_n_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef CCFF_VERIFY_EN
    par_d       = par_q;
    tpar_d      = tpar_q;
`endif

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.start) begin
          state_d    = S_ISOLATE;
          err_d      = 1'b0;
          isol_n_d   = 1'b0;
          iso_cnt_d  = '0;
          bit_cnt_d  = '0;
          word_idx_d = '0;
`ifdef CCFF_VERIFY_EN
          par_d      = 1'b0;
`endif
        end
      end

      S_ISOLATE: begin
        if (iso_cnt_q == ISO_LAST) begin
          state_d     = S_LOAD;
          cfg_ready_d = 1'b1;
        end else begin
          iso_cnt_d = iso_cnt_q + 1'b1;
        end
      end

      S_LOAD: begin
        if (shift_en_q) begin
          // The bit on ccff_head enters the chain at this edge.
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef CCFF_VERIFY_EN
          par_d     = par_q ^ ccff_head_q;
`endif
          if (bits_left_q != '0) begin
            ccff_head_d = word_q[0];
            word_d      = word_q >> 1;
            bits_left_d = bits_left_q - 1'b1;
          end else begin
            shift_en_d = 1'b0;
            if (bit_cnt_q == LAST_CNT) begin
              bit_cnt_d = '0;
`ifdef CCFF_VERIFY_EN
              state_d    = S_VERIFY;
              shift_en_d = 1'b1;
              tpar_d     = 1'b0;
`else
              state_d    = S_RELEASE;
              iso_cnt_d  = '0;
`endif
            end else begin
              cfg_ready_d = 1'b1;
            end
          end
        end else if (cfg_ready_q && bus.cfg_valid) begin
          cfg_ready_d = 1'b0;
          if (bus.cfg_last != (word_idx_q == LAST_IDX)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            word_idx_d  = word_idx_q + 1'b1;
            ccff_head_d = bus.cfg_data[0];
            word_d      = bus.cfg_data >> 1;
            bits_left_d = bus.cfg_last ? LAST_LEFT : FULL_LEFT;
            shift_en_d  = 1'b1;
          end
        end
      end

`ifdef CCFF_VERIFY_EN
      S_VERIFY: begin
        tpar_d    = tpar_q ^ bus.ccff_tail;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_CNT) begin
          shift_en_d = 1'b0;
          bit_cnt_d  = '0;
          if ((tpar_q ^ bus.ccff_tail) != par_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d   = S_RELEASE;
            iso_cnt_d = '0;
          end
        end
      end
`endif

      S_RELEASE: begin
        if (iso_cnt_q == ISO_LAST) begin
          state_d  = S_IDLE;
          isol_n_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          iso_cnt_d = iso_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_ERR));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= S_IDLE;
      iso_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      bits_left_q <= '0;
      word_q      <= '0;
      cfg_ready_q <= 1'b0;
      ccff_head_q <= 1'b0;
      shift_en_q  <= 1'b0;
      isol_n_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef CCFF_VERIFY_EN
      par_q       <= 1'b0;
      tpar_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      iso_cnt_q   <= iso_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      bits_left_q <= bits_left_d;
      word_q      <= word_d;
      cfg_ready_q <= cfg_ready_d;
      ccff_head_q <= ccff_head_d;
      shift_en_q  <= shift_en_d;
      isol_n_q    <= isol_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef CCFF_VERIFY_EN
      par_q       <= par_d;
      tpar_q      <= tpar_d;
`endif
    end
  end

`ifdef CCFF_VERIFY_EN
  // Recirculation must close the loop with no extra stage, so head follows tail directly while verifying.
  assign bus.ccff_head = (state_q == S_VERIFY) ? bus.ccff_tail : ccff_head_q;
`else
  assign bus.ccff_head = ccff_head_q;
  logic unused_tail;
  assign unused_tail = bus.ccff_tail;
`endif

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.ccff_shift_en = shift_en_q;
  assign bus.isol_n        = isol_n_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_io_ccff_loader.sv
// Self-checking bench for io_ccff_loader: a 12-bit and a 16-bit chain instance, each with a behavioural chain model.
// The expected bit stream is simply the words concatenated LSB first and truncated to the chain length.
module tb_io_ccff_loader;
  localparam int ISO = 4;
`ifdef CCFF_VERIFY_EN
  localparam int VMUL = 2;
`else
  localparam int VMUL = 1;
`endif

  logic       prog_clk = 1'b0;
  logic       prog_reset = 1'b1;
  logic       start_r = 1'b0;
  logic       valid_r = 1'b0;
  logic       last_r = 1'b0;
  logic [7:0] data_r = 8'h00;
  logic       sel16 = 1'b0;
  logic       fault_en = 1'b0;
  int         fault_at = 0;

  logic [11:0] chain12 = '0;
  logic [15:0] chain16 = '0;
  int          sh12 = 0;

  int checks = 0;
  int errors = 0;

  io_ccff_loader_if #(.WORD_W(8)) if12 ();
  io_ccff_loader_if #(.WORD_W(8)) if16 ();

  assign if12.start     = start_r & ~sel16;
  assign if12.cfg_valid = valid_r & ~sel16;
  assign if12.cfg_data  = data_r;
  assign if12.cfg_last  = last_r;
  assign if12.ccff_tail = chain12[11];
  assign if16.start     = start_r & sel16;
  assign if16.cfg_valid = valid_r & sel16;
  assign if16.cfg_data  = data_r;
  assign if16.cfg_last  = last_r;
  assign if16.ccff_tail = chain16[15];

  io_ccff_loader #(.CHAIN_LEN(12), .WORD_W(8), .ISO_CYCLES(ISO)) dut12 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(if12));
  io_ccff_loader #(.CHAIN_LEN(16), .WORD_W(8), .ISO_CYCLES(ISO)) dut16 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(if16));

  always #5 prog_clk = ~prog_clk;

  wire o_ready = sel16 ? if16.cfg_ready     : if12.cfg_ready;
  wire o_head  = sel16 ? if16.ccff_head     : if12.ccff_head;
  wire o_shen  = sel16 ? if16.ccff_shift_en : if12.ccff_shift_en;
  wire o_isol  = sel16 ? if16.isol_n        : if12.isol_n;
  wire o_busy  = sel16 ? if16.busy          : if12.busy;
  wire o_done  = sel16 ? if16.done          : if12.done;
  wire o_err   = sel16 ? if16.err           : if12.err;

  // Chain models; the 12-bit one can store one chosen bit inverted to emulate a faulty cell.
  always @(posedge prog_clk) begin
    if (if12.ccff_shift_en) begin
      chain12 <= {chain12[10:0], if12.ccff_head ^ (fault_en && (sh12 == fault_at))};
      sh12    <= sh12 + 1;
    end
    if (if16.ccff_shift_en) chain16 <= {chain16[14:0], if16.ccff_head};
  end

  // Records the head bit of every shift-enabled cycle of the selected instance.
  logic hq[$];
  int   cyc = 0;
  int   last_sh = 0;
  int   done_cnt = 0;
  always @(posedge prog_clk) begin
    if (o_shen) begin
      hq.push_back(o_head);
      last_sh = cyc;
    end
    if (o_done) done_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    int n = 0;
    hq.delete();
    fault_at = sh12 + 5;
    start_r = 1'b1;
    @(negedge prog_clk);
    start_r = 1'b0;
    check("start_state", {o_isol, o_busy, o_err}, 3'b010);
    while (!o_ready && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    check("iso_len", n, ISO);
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, input int gap, input bit poke);
    int n = 0;
    int sz;
    bit hold_ok = 1'b1;
    while (!o_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    check("ready_wait", n < 100, 1);
    sz = hq.size();
    for (int i = 0; i < gap; i++) begin
      start_r = poke && (i == 0);
      if (o_shen || !o_ready) hold_ok = 1'b0;
      @(negedge prog_clk);
    end
    start_r = 1'b0;
    check("gap_hold", {hold_ok, hq.size() == sz}, 2'b11);
    data_r  = d;
    last_r  = l;
    valid_r = 1'b1;
    @(negedge prog_clk);
    valid_r = 1'b0;
  endtask

  task automatic wait_end(output bit dn, output bit er, output bit iso_viol);
    int n = 0;
    iso_viol = 1'b0;
    while (n < 400) begin
      if (o_done || o_err) break;
      if (o_isol) iso_viol = 1'b1;
      @(negedge prog_clk);
      n++;
    end
    dn = o_done;
    er = o_err;
  endtask

  task automatic full_load(input bit use16, input logic [7:0] w0, input logic [7:0] w1,
                           input int gap, input bit poke);
    int          n;
    int          d0;
    bit          dn, er, iv;
    logic [15:0] strm;
    logic [15:0] echain;
    logic [31:0] exp_q;
    logic [31:0] got_q;
    sel16  = use16;
    n      = use16 ? 16 : 12;
    d0     = done_cnt;
    strm   = {w1, w0};
    echain = '0;
    exp_q  = '0;
    got_q  = '0;
    for (int i = 0; i < n; i++) echain[n-1-i] = strm[i];
    for (int k = 0; k < VMUL; k++)
      for (int i = 0; i < n; i++) exp_q[k*n+i] = strm[i];

    do_start();
    send_word(w0, 1'b0, 0, 1'b0);
    send_word(w1, 1'b1, gap, poke);
    wait_end(dn, er, iv);
    check("end_done", {dn, er, iv}, 3'b100);
    check("release_len", cyc - last_sh, ISO + 1);
    check("after_state", {o_isol, o_busy, o_ready, o_shen}, 4'b1000);
    for (int i = 0; i < hq.size() && i < 32; i++) got_q[i] = hq[i];
    check("shift_count", hq.size(), VMUL * n);
    check("stream", got_q, exp_q);
    check("chain", use16 ? chain16 : {4'b0000, chain12}, echain);
    @(negedge prog_clk);
    check("done_pulse", {o_done, o_isol}, 2'b01);
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    bit          dn, er, iv;
    int          n;
    logic [31:0] rv;

    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge prog_clk);
    check("reset_vals", {o_ready, o_head, o_shen, o_isol, o_busy, o_done, o_err}, 7'b0);
    prog_reset = 1'b0;
    @(negedge prog_clk);

    // cfg_valid outside LOAD must not be accepted.
    data_r = 8'hFF; last_r = 1'b1; valid_r = 1'b1;
    repeat (3) @(negedge prog_clk);
    check("idle_valid", {o_ready, o_busy, o_err, hq.size() == 0}, 4'b0001);
    valid_r = 1'b0;

    full_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0);

    // cfg_last on the first word.
    sel16 = 1'b0;
    do_start();
    send_word(8'hFF, 1'b1, 0, 1'b0);
    check("err_first", {o_err, o_busy, o_isol, o_ready, o_shen}, 5'b10000);
    check("err_first_noshift", hq.size(), 0);
    repeat (3) @(negedge prog_clk);
    check("err_sticky", {o_err, o_isol, o_done, hq.size() == 0}, 4'b1001);
    full_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0);

    // Final word arrives without cfg_last.
    do_start();
    send_word(8'h12, 1'b0, 0, 1'b0);
    send_word(8'h34, 1'b0, 0, 1'b0);
    check("err_nolast", {o_err, o_busy, o_isol, o_ready, o_shen}, 5'b10000);
    check("err_nolast_bits", hq.size(), 8);

    // Starved LOAD, with an ignored start inside the gap.
    full_load(1'b0, 8'h5A, 8'hC3, 5, 1'b1);

    // Asynchronous reset after six shifted bits.
    sel16 = 1'b0;
    do_start();
    send_word(8'hA5, 1'b0, 0, 1'b0);
    n = 0;
    while (hq.size() < 6 && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    check("six_bits", hq.size(), 6);
    #1 prog_reset = 1'b1;
    #1 check("async_reset", {o_ready, o_head, o_shen, o_isol, o_busy, o_done, o_err}, 7'b0);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    @(negedge prog_clk);
    full_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0);

    // Exact-multiple chain: no bits discarded.
    full_load(1'b1, 8'h01, 8'h80, 0, 1'b0);

    for (int r = 0; r < 4; r++)
      full_load(1'b0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    for (int r = 0; r < 2; r++)
      full_load(1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 1'b0);

`ifdef CCFF_VERIFY_EN
    begin
      bit dn, er, iv;
      sel16    = 1'b0;
      fault_en = 1'b1;
      do_start();
      send_word(8'($urandom), 1'b0, 0, 1'b0);
      send_word(8'($urandom), 1'b1, 0, 1'b0);
      wait_end(dn, er, iv);
      check("verify_fault_end", {dn, er, iv}, 3'b010);
      check("verify_fault_shifts", hq.size(), 24);
      check("verify_fault_state", {o_err, o_busy, o_isol, o_ready}, 4'b1000);
      repeat (2) @(negedge prog_clk);
      check("verify_fault_sticky", {o_err, o_isol, o_done}, 3'b100);
      fault_en = 1'b0;
      full_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
